// File: rtl/noc_flit_tx.sv
// Source-side packetizer: serialises a descriptor plus payload stream into header/body/tail flits
// for the port arbiter. Optional statistics counters are enabled with FLIT_TX_STATS_EN.
module noc_flit_tx #(
  parameter int DATA_W = 32,
  parameter int SLACK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [11:0]       pkt_flits,
  input  logic [DATA_W-1:0] pkt_header,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              req,
  input  logic              grant,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic [DATA_W-1:0] flit_data,
  output logic              flit_valid
`ifdef FLIT_TX_STATS_EN
  ,
  output logic [15:0]       stat_pkts,
  output logic [15:0]       stat_preempt,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam logic [2:0] ID_NONE = 3'b000;
  localparam logic [2:0] ID_HEAD = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  state_t            state, state_nxt;
  logic [11:0]       remaining, remaining_nxt;
  logic              req_nxt;
  logic              flit_valid_nxt;
  logic [2:0]        flit_id_nxt;
  logic [11:0]       length_nxt;
  logic [DATA_W-1:0] flit_data_nxt;
  logic              transfer;
  logic              load;
  logic [11:0]       nflits;
  logic [12:0]       len_sum;

  assign transfer  = flit_valid & grant;
  assign pkt_ready = (state == IDLE);
  // remaining counts flits not yet loaded, so it is nonzero in HEAD/BODY and guards underflow
  assign data_ready = ((state == HEAD) || (state == BODY)) && (remaining != 12'd0) &&
                      (!flit_valid || grant);
  assign load    = data_ready & data_valid;
  assign nflits  = (pkt_flits < 12'd2) ? 12'd2 : pkt_flits;
  assign len_sum = {1'b0, nflits} + 13'(SLACK);

  // Next-state and next-output computation
  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    req_nxt        = req;
    flit_valid_nxt = flit_valid;
    flit_id_nxt    = flit_id;
    length_nxt     = length;
    flit_data_nxt  = flit_data;
    case (state)
      IDLE: begin
        if (pkt_valid) begin
          state_nxt      = HEAD;
          remaining_nxt  = nflits - 12'd1;
          req_nxt        = 1'b1;
          flit_valid_nxt = 1'b1;
          flit_id_nxt    = ID_HEAD;
          flit_data_nxt  = pkt_header;
          length_nxt     = len_sum[12] ? 12'hFFF : len_sum[11:0];
        end else begin
          state_nxt = IDLE;
        end
      end
      HEAD, BODY: begin
        if (load) begin
          flit_valid_nxt = 1'b1;
          flit_data_nxt  = data_in;
          remaining_nxt  = remaining - 12'd1;
          if (remaining == 12'd1) begin
            flit_id_nxt = ID_TAIL;
            state_nxt   = TAIL;
          end else begin
            flit_id_nxt = ID_BODY;
            state_nxt   = BODY;
          end
        end else if (transfer) begin
          // flit left but no word ready: a gap, request stays up
          flit_valid_nxt = 1'b0;
          flit_id_nxt    = ID_NONE;
          state_nxt      = BODY;
        end else begin
          state_nxt = state;
        end
      end
      TAIL: begin
        if (transfer) begin
          state_nxt      = IDLE;
          remaining_nxt  = 12'd0;
          req_nxt        = 1'b0;
          flit_valid_nxt = 1'b0;
          flit_id_nxt    = ID_NONE;
          length_nxt     = 12'd0;
          flit_data_nxt  = {DATA_W{1'b0}};
        end else begin
          state_nxt = TAIL;
        end
      end
      default: begin
        state_nxt      = IDLE;
        remaining_nxt  = 12'd0;
        req_nxt        = 1'b0;
        flit_valid_nxt = 1'b0;
        flit_id_nxt    = ID_NONE;
        length_nxt     = 12'd0;
        flit_data_nxt  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= 12'd0;
      req        <= 1'b0;
      flit_valid <= 1'b0;
      flit_id    <= ID_NONE;
      length     <= 12'd0;
      flit_data  <= {DATA_W{1'b0}};
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      req        <= req_nxt;
      flit_valid <= flit_valid_nxt;
      flit_id    <= flit_id_nxt;
      length     <= length_nxt;
      flit_data  <= flit_data_nxt;
    end
  end

`ifdef FLIT_TX_STATS_EN
  logic grant_prev;

  // Packet, preemption and stall counters; all wrap at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_prev   <= 1'b0;
      stat_pkts    <= 16'd0;
      stat_preempt <= 16'd0;
      stat_stall   <= 16'd0;
    end else begin
      grant_prev <= grant;
      if ((state == TAIL) && transfer) begin
        stat_pkts <= stat_pkts + 16'd1;
      end
      if (grant_prev && !grant && req) begin
        stat_preempt <= stat_preempt + 16'd1;
      end
      if (req && !grant) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule
